// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package imem_pkg;

    localparam int          DEPTH   = 100;      // 16-bit words in the instruction memory
    localparam int          AW      = 7;        // word-address width, 2**AW >= DEPTH
    localparam logic [3:0]  HALT_OP = 4'hF;     // opcode in instr[15:12] that stops fetching
    localparam logic [15:0] NOP     = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    // Requester identity; also the bit position in the arbiter request/grant vectors.
    typedef enum logic {
        FETCH  = 1'b0,
        LOADER = 1'b1
    } req_e;

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 = fetch, bit 1 = loader.
// On a tie the requester that did not win last time is granted; the
// last-winner register resets to FETCH so the loader wins the first tie.
module rr_arb2
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_e last_q;
    req_e last_d;

    // Grant selection and last-winner update.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (req[0] && req[1]) begin
            if (last_q == FETCH) begin
                gnt[1] = 1'b1;
            end else begin
                gnt[0] = 1'b1;
            end
        end else begin
            gnt = req;
        end
        if (gnt[0]) begin
            last_d = FETCH;
        end else if (gnt[1]) begin
            last_d = LOADER;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= FETCH;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port synchronous memory
// between the fetch stage (read, byte PC) and the loader (write, word address).
// One access per cycle, one-cycle read latency, fetch stops on HALT_OP.
// Optional build macro IMEM_ADDR_CHECK_EN: out-of-range accesses are granted
// but do not strobe memory, fetches return NOP, and sticky addr_err is set.
//
// Handshake: a requester holds req (and its address/data) until it sees gnt in
// the same cycle; gnt is the acceptance. f_valid follows f_gnt by exactly one
// cycle with no backpressure. halted is the FSM state (1 = HALTED).
module imem_arbiter
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [15:0]   f_pc,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [15:0]   f_instr,
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [15:0]   l_wdata,
    output logic          l_gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic          halted
`ifdef IMEM_ADDR_CHECK_EN
    ,
    output logic          addr_err
`endif
);

    state_e        state_q, state_d;
    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    req, gnt;
    logic          pc_unused;

`ifdef IMEM_ADDR_CHECK_EN
    logic          nop_q, nop_d;
    logic          err_q, err_d;
`endif

    // The byte-select bit never addresses memory.
    assign pc_unused = f_pc[0] ^ (^f_pc[15:AW+1]);

    // Eligible requesters; nothing is granted while reset is asserted.
    always_comb begin
        req    = 2'b00;
        req[0] = f_req && (state_q == RUN) && !rst;
        req[1] = l_req && !rst;
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    // Memory-port muxing for the winner; address/data hold when idle.
    always_comb begin
        f_gnt     = gnt[0];
        l_gnt     = gnt[1];
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_pend_d = 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
        nop_d     = 1'b0;
        err_d     = err_q;
`endif
        if (gnt[0]) begin
            addr_d    = f_pc[AW:1];
            mem_en    = 1'b1;
            rd_pend_d = 1'b1;
`ifdef IMEM_ADDR_CHECK_EN
            if (f_pc[15:1] >= 15'(DEPTH)) begin
                mem_en = 1'b0;
                nop_d  = 1'b1;
                err_d  = 1'b1;
            end
`endif
        end else if (gnt[1]) begin
            addr_d  = l_addr;
            wdata_d = l_wdata;
            mem_en  = 1'b1;
            mem_we  = 1'b1;
`ifdef IMEM_ADDR_CHECK_EN
            if (l_addr >= AW'(DEPTH)) begin
                mem_en = 1'b0;
                mem_we = 1'b0;
                err_d  = 1'b1;
            end
`endif
        end
        mem_addr  = addr_d;
        mem_wdata = wdata_d;
    end

    // Fetch response: read data passes straight through in the cycle after the grant.
    always_comb begin
        f_valid = rd_pend_q;
`ifdef IMEM_ADDR_CHECK_EN
        f_instr = (rd_pend_q && !nop_q) ? mem_rdata : NOP;
`else
        f_instr = rd_pend_q ? mem_rdata : NOP;
`endif
    end

    // Halt FSM next state: HALT response stops fetch, any loader write restarts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (f_valid && (f_instr[15:12] == HALT_OP)) state_d = HALTED;
            HALTED:  if (l_gnt) state_d = RUN;
            default: state_d = RUN;
        endcase
        halted = (state_q == HALTED);
    end

    // State, pending-read flag and held memory address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            rd_pend_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef IMEM_ADDR_CHECK_EN
    // Out-of-range bookkeeping: NOP marker for the response and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nop_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            nop_q <= nop_d;
            err_q <= err_d;
        end
    end

    assign addr_err = err_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic, every
// cycle checked against a cycle-level reference model with a shadow memory.
module tb_imem_arbiter;
    import imem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          f_req = 1'b0;
    logic [15:0]   f_pc = '0;
    logic          f_gnt, f_valid, l_gnt, mem_en, mem_we, halted;
    logic [15:0]   f_instr, mem_wdata;
    logic          l_req = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [15:0]   l_wdata = '0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata = '0;
`ifdef IMEM_ADDR_CHECK_EN
    logic          addr_err;
`endif

    imem_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_pc(f_pc), .f_gnt(f_gnt), .f_valid(f_valid), .f_instr(f_instr),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .halted(halted)
`ifdef IMEM_ADDR_CHECK_EN
        , .addr_err(addr_err)
`endif
    );

    // Single-port synchronous memory driven by the DUT.
    logic [15:0] mem [0:127];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // ---------------- reference model state ----------------
    logic [15:0]   ref_mem [0:127];
    logic [15:0]   exp_q [$];        // expected fetch responses, oldest first
    bit            m_last_ld;        // last winner was the loader
    bit            m_halted;
    bit            m_err;
    logic [AW-1:0] m_addr;

    int n_checks = 0;
    int n_pass   = 0;

    // Values sampled during the most recent step, for directed checks.
    logic        s_f_gnt, s_l_gnt, s_f_valid, s_halted;
    logic [15:0] s_f_instr;

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge: drive inputs, check at the falling edge,
    // advance the model, return just after the next rising edge.
    task automatic step(input logic fr, input logic [15:0] pc, input logic lr,
                        input logic [AW-1:0] la, input logic [15:0] ld);
        logic fe, win_f, win_l, f_oob, l_oob, e_en, e_we, e_valid;
        logic [AW-1:0] e_addr;
        logic [15:0]   e_instr;
        f_req = fr; f_pc = pc; l_req = lr; l_addr = la; l_wdata = ld;
        @(negedge clk);
        fe    = fr && !m_halted;
        win_l = lr && (!fe || !m_last_ld);
        win_f = fe && !win_l;
        f_oob = 1'b0;
        l_oob = 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
        f_oob = win_f && (int'(pc >> 1) >= DEPTH);
        l_oob = win_l && (int'(la) >= DEPTH);
`endif
        e_en    = (win_f && !f_oob) || (win_l && !l_oob);
        e_we    = win_l && !l_oob;
        e_addr  = win_f ? pc[AW:1] : (win_l ? la : m_addr);
        e_valid = (exp_q.size() != 0);
        e_instr = e_valid ? exp_q.pop_front() : 16'h0;

        check_eq("f_gnt", f_gnt, win_f);
        check_eq("l_gnt", l_gnt, win_l);
        check_eq("mem_en", mem_en, e_en);
        check_eq("mem_we", mem_we, e_we);
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("f_valid", f_valid, e_valid);
        check_eq("halted", halted, m_halted);
        if (e_valid) check_eq("f_instr", f_instr, e_instr);
        if (win_l)   check_eq("mem_wdata", mem_wdata, ld);
`ifdef IMEM_ADDR_CHECK_EN
        check_eq("addr_err", addr_err, m_err);
`endif
        s_f_gnt = f_gnt; s_l_gnt = l_gnt; s_f_valid = f_valid;
        s_halted = halted; s_f_instr = f_instr;

        // Advance the model to the next cycle.
        if (m_halted) begin
            if (win_l) m_halted = 1'b0;
        end else if (e_valid && (e_instr[15:12] == HALT_OP)) begin
            m_halted = 1'b1;
        end
        if (win_f) exp_q.push_back(f_oob ? NOP : ref_mem[pc[AW:1]]);
        if (win_l && !l_oob) ref_mem[la] = ld;
        if (win_f || win_l) m_last_ld = win_l;
        if (f_oob || l_oob) m_err = 1'b1;
        m_addr = e_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; f_req = 1'b0; l_req = 1'b0;
        #1;
        check_eq("rst_f_valid", f_valid, 1'b0);
        check_eq("rst_f_gnt", f_gnt, 1'b0);
        check_eq("rst_l_gnt", l_gnt, 1'b0);
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_halted", halted, 1'b0);
`ifdef IMEM_ADDR_CHECK_EN
        check_eq("rst_addr_err", addr_err, 1'b0);
`endif
        exp_q.delete();
        m_halted = 1'b0; m_last_ld = 1'b0; m_err = 1'b0; m_addr = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]    seq;
        logic          fr, lr;
        logic [15:0]   pc, ld;
        logic [AW-1:0] la;

        // Initial contents avoid HALT words so the directed part is predictable.
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = 16'($urandom_range(0, 16'hEFFF));
            mem[i]     = ref_mem[i];
        end
        apply_reset();

        // Both requesting every cycle: loader first, then strict alternation.
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'h0010 + 16'(i * 2), 1'b1, AW'(i), 16'h1000 + 16'(i));
            seq[i] = s_l_gnt;
            check_eq("tie_one_gnt", s_f_gnt ^ s_l_gnt, 1'b1);
        end
        check_eq("tie_seq", seq, 6'b010101);
        step(1'b0, 16'h0, 1'b0, '0, 16'h0);

        // Loader write then fetch of the same word.
        step(1'b0, 16'h0, 1'b1, AW'(1), 16'h8A01);
        check_eq("wr_l_gnt", s_l_gnt, 1'b1);
        step(1'b1, 16'h0002, 1'b0, '0, 16'h0);
        check_eq("rd_f_gnt", s_f_gnt, 1'b1);
        step(1'b0, 16'h0, 1'b0, '0, 16'h0);
        check_eq("rd_valid", s_f_valid, 1'b1);
        check_eq("rd_instr", s_f_instr, 16'h8A01);

        // HALT word at 13, fetched from byte PC 0x1A; overlapping fetch completes.
        step(1'b0, 16'h0, 1'b1, AW'(13), 16'hF000);
        step(1'b1, 16'h001A, 1'b0, '0, 16'h0);
        step(1'b1, 16'h0004, 1'b0, '0, 16'h0);
        check_eq("halt_instr", s_f_instr, 16'hF000);
        check_eq("halt_overlap_gnt", s_f_gnt, 1'b1);
        step(1'b1, 16'h0004, 1'b0, '0, 16'h0);
        check_eq("halted_set", s_halted, 1'b1);
        check_eq("halted_no_gnt", s_f_gnt, 1'b0);
        step(1'b1, 16'h0004, 1'b0, '0, 16'h0);
        check_eq("halted_no_gnt2", s_f_gnt, 1'b0);

        // Loader write releases the halt.
        step(1'b1, 16'h0004, 1'b1, AW'(0), 16'h1234);
        check_eq("unhalt_l_gnt", s_l_gnt, 1'b1);
        step(1'b1, 16'h0004, 1'b0, '0, 16'h0);
        check_eq("unhalt_cleared", s_halted, 1'b0);
        check_eq("unhalt_f_gnt", s_f_gnt, 1'b1);
        step(1'b0, 16'h0, 1'b0, '0, 16'h0);

        // Reset in the cycle after a fetch grant drops the in-flight read.
        step(1'b1, 16'h0006, 1'b0, '0, 16'h0);
        check_eq("pre_rst_f_gnt", s_f_gnt, 1'b1);
        apply_reset();
        step(1'b1, 16'h0008, 1'b1, AW'(7), 16'h2222);
        check_eq("post_rst_tie", s_l_gnt, 1'b1);
        step(1'b1, 16'h0008, 1'b0, '0, 16'h0);

`ifdef IMEM_ADDR_CHECK_EN
        // Word 100 is out of range: granted, no strobe, NOP response, sticky error.
        step(1'b1, 16'h00C8, 1'b0, '0, 16'h0);
        check_eq("oob_f_gnt", s_f_gnt, 1'b1);
        step(1'b0, 16'h0, 1'b0, '0, 16'h0);
        check_eq("oob_instr", s_f_instr, 16'h0000);
        check_eq("oob_err", addr_err, 1'b1);
`endif

        // Randomized traffic; requests are held until granted.
        fr = 1'b0; lr = 1'b0; pc = '0; la = '0; ld = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!fr && ($urandom_range(0, 3) != 0)) begin
                fr = 1'b1;
                if ($urandom_range(0, 3) == 0) pc = 16'($urandom);
                else                           pc = 16'($urandom_range(0, 255));
            end
            if (!lr && ($urandom_range(0, 4) == 0)) begin
                lr = 1'b1;
                la = AW'($urandom_range(0, 127));
                if ($urandom_range(0, 5) == 0) ld = {4'hF, 12'($urandom)};
                else                           ld = 16'($urandom);
            end
            step(fr, pc, lr, la, ld);
            if (s_f_gnt) fr = 1'b0;
            if (s_l_gnt) lr = 1'b0;
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
                fr = 1'b0;
                lr = 1'b0;
            end
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port synchronous instruction memory between two requesters: the CPU fetch stage (read-only, byte PC) and the program loader/debug port (write-only, word address).
- Round-robin arbitration, one memory access per cycle, one-cycle read latency.
- Detects the HALT opcode (4'hF in bits [15:12]) on returned fetch words and blocks further fetches until the loader reprograms memory or reset.
- Sits between the fetch stage, the loader and the memory array.

Parameters:
- DEPTH, 100, number of 16-bit words in the instruction memory.
- AW, 7, memory word-address width; must satisfy 2**AW >= DEPTH.
- HALT_OP, 4'hF, opcode in instr[15:12] that halts fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request.
- f_pc  in  16  fetch byte address; word index = f_pc[15:1].
- f_gnt  out  1  fetch access issued this cycle.
- f_valid  out  1  f_instr valid this cycle.
- f_instr  out  16  fetched instruction word.
- l_req  in  1  loader write request.
- l_addr  in  AW  loader word address.
- l_wdata  in  16  loader write data.
- l_gnt  out  1  loader write issued this cycle.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid the cycle after a read strobe.
- halted  out  1  HALT seen; fetch blocked.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; state = RUN; rd_pend = 0; rr_last = FETCH, so the loader wins the first tie after reset.
- States:
  - RUN: both requesters eligible.
  - HALTED: only the loader is eligible; f_gnt is held at 0.
- Arbitration is combinational within the cycle.
  - Eligible requesters: f_req (only in RUN), l_req.
  - Exactly one eligible requester wins.
  - If both are eligible, the one not equal to rr_last wins.
  - rr_last updates to the winner on every grant.
- Grant cycle, fetch:
  - mem_en = 1, mem_we = 0, mem_addr = f_pc[AW:1], f_gnt = 1.
  - rd_pend is set for the next cycle.
- Grant cycle, loader:
  - mem_en = 1, mem_we = 1, mem_addr = l_addr, mem_wdata = l_wdata, l_gnt = 1.
- No grant: mem_en = 0, mem_we = 0; mem_addr and mem_wdata hold their last values.
- Fetch response:
  - The cycle after f_gnt: f_valid = 1 and f_instr = mem_rdata (combinational pass-through).
  - Latency is exactly 1 cycle; there is no backpressure on f_valid.
- Requesters hold their request until granted; request signals are sampled only in the grant cycle.
- Halt detection:
  - If f_valid and f_instr[15:12] == HALT_OP, the state moves RUN -> HALTED at the next edge and halted = 1.
  - A fetch granted in the same cycle as the HALT response completes normally; this is a one-deep overlap with no squash.
- HALTED -> RUN on any loader grant; halted clears at the following edge.
- Read-after-write: a fetch granted the cycle after a loader write to the same address returns the new data (memory write-first or a separate cycle; no forwarding required).
- f_pc[0] is ignored.
- Addresses >= DEPTH are passed through unchanged unless IMEM_ADDR_CHECK_EN is defined.
- Reset asserted mid-access: rd_pend clears immediately and no f_valid is produced for the in-flight read.

Optional Feature:
- IMEM_ADDR_CHECK_EN, defined:
  - A fetch whose word index is >= DEPTH is still granted but does not strobe memory (mem_en = 0).
  - Next cycle: f_valid = 1 with f_instr = 16'h0000 (NOP).
  - A sticky output addr_err (1 bit, reset 0) is set.
  - A loader write with l_addr >= DEPTH is granted and dropped (mem_en = 0) and also sets addr_err.
- IMEM_ADDR_CHECK_EN, undefined: no range check, and the addr_err port is absent.

Decomposition:
- Shared package imem_pkg: DEPTH, AW, HALT_OP, the state enum {RUN, HALTED}, the requester enum {FETCH, LOADER}, and the NOP constant 16'h0000.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with grant vector and last-winner register. The FSM and datapath muxing stay in the top module.

Test Plan:
- Loader writes word 1 = 16'h8A01 at l_addr 1, then fetch f_pc = 16'h0002 -> mem_we pulse at addr 1; next fetch f_valid one cycle after f_gnt with f_instr = 16'h8A01.
- f_req and l_req held high together for 6 cycles after reset -> grants alternate L, F, L, F, L, F; exactly one mem_en per cycle.
- Memory word 13 = 16'hF000, fetch f_pc = 16'h001A -> halted = 1 one cycle after f_valid; f_req held high gives f_gnt = 0 thereafter.
- While halted, loader writes addr 0 -> halted = 0 next cycle; a subsequent f_req is granted.
- rst pulsed in the cycle after f_gnt -> f_valid stays 0; outputs are 0; the first tie after reset goes to the loader.
- With IMEM_ADDR_CHECK_EN, fetch f_pc = 16'h00C8 (word 100) -> mem_en = 0, f_instr = 16'h0000 with f_valid = 1, addr_err = 1 and sticky until rst.
